// File: rtl/ad_ip_jesd204_tpl_dac_buffer.sv
// Prefill buffer in front of the JESD204 TPL DAC core: holds DMA words in a small
// circular FIFO, starts serving once PREFILL words are buffered, and serves zeros with dac_dunf on starvation.
module ad_ip_jesd204_tpl_dac_buffer #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 4,
  parameter int PREFILL      = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic [NUM_CHANNELS-1:0] dac_valid,
  output logic [DATA_WIDTH-1:0]   dac_ddata,
  output logic                    dac_dunf,
  output logic [ADDR_WIDTH:0]     fifo_level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEVEL_PREFILL = (ADDR_WIDTH + 1)'(PREFILL);
  localparam logic [ADDR_WIDTH:0] LEVEL_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     level_q, level_d;
  logic [DATA_WIDTH-1:0]   ddata_q, ddata_d;
  logic                    dunf_q, dunf_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic active;
  logic req;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign active = |enable;
  assign req    = |dac_valid;
  assign full   = (level_q == LEVEL_FULL);
  assign empty  = (level_q == '0);

  // No full-bypass: a pop in a full cycle does not open ready until the next cycle.
  assign s_axis_ready = (state_q != ST_IDLE) & active & !full;
  assign push         = s_axis_valid & s_axis_ready;
  assign pop          = (state_q == ST_RUN) & req & !empty;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ddata_d  = ddata_q;
    dunf_d   = dunf_q;

    if (!active) begin
      // Losing all enables flushes the buffer regardless of state.
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ddata_d  = '0;
      dunf_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          state_d  = ST_PREFILL;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
        end
        ST_PREFILL: begin
          if (req) begin
            ddata_d = '0;
            dunf_d  = 1'b1;
          end
          if (level_d >= LEVEL_PREFILL) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (req) begin
            if (pop) begin
              ddata_d = mem[rd_ptr_q];
              dunf_d  = 1'b0;
            end else begin
              ddata_d = '0;
              dunf_d  = 1'b1;
              state_d = ST_PREFILL;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ddata_q  <= '0;
      dunf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ddata_q  <= ddata_d;
      dunf_q   <= dunf_d;
    end
  end

  // Storage carries no reset; zeroed pointers make old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_axis_data;
  end

  assign dac_ddata  = ddata_q;
  assign dac_dunf   = dunf_q;
  assign fifo_level = level_q;

endmodule
